// File: rtl/dii_glip_serializer_pkg.sv
// Shared types for the DI-to-GLIP serializer and its matching deserializer.
// Holds the dii_flit bundle, the GLIP length-word width and the FSM state enum.
package dii_glip_serializer_pkg;

   localparam int GLIP_LEN_WORD_W = 16;

   typedef struct packed {
      logic        valid;
      logic        last;
      logic [15:0] data;
   } dii_flit;

   typedef enum logic [1:0] {
      COLLECT,
      SEND_LEN,
      SEND_DATA
   } ser_state_e;

endpackage

// File: rtl/dii_pkt_buffer.sv
// Packet buffer: DEPTH x WIDTH register file, one write and one comb read port.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (combinational read).
module dii_pkt_buffer #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/dii_glip_serializer.sv
// Host-bound serializer: buffers a whole DI packet, then emits a length word
// followed by its flits on a GLIP FIFO channel. Ports: clk, rst (sync, high),
// in_flit/in_ready (DI side), out_data/out_valid/out_ready (GLIP side),
// err_overflow (one-cycle pulse on truncated packet), busy (sending).
module dii_glip_serializer
   import dii_glip_serializer_pkg::*;
#(
   parameter int MAX_PKT_LEN = 8,
   parameter int WIDTH       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  dii_flit          in_flit,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             err_overflow,
   output logic             busy
);

   localparam int CW = $clog2(MAX_PKT_LEN + 1);
   localparam int AW = $clog2(MAX_PKT_LEN);

   ser_state_e       state_q, state_d;
   logic [CW-1:0]    wr_cnt_q, wr_cnt_d;
   logic [CW-1:0]    rd_cnt_q, rd_cnt_d;
   logic             ovf_q, ovf_d;
   logic             err_q, err_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             busy_q, busy_d;

   logic             accept;
   logic             full;
   logic             buf_we;
   logic [WIDTH-1:0] rd_data;

   dii_pkt_buffer #(
      .DEPTH (MAX_PKT_LEN),
      .WIDTH (WIDTH)
   ) u_buf (
      .clk   (clk),
      .we    (buf_we),
      .waddr (wr_cnt_q[AW-1:0]),
      .wdata (in_flit.data),
      .raddr (rd_cnt_d[AW-1:0]),
      .rdata (rd_data)
   );

   always_comb begin
      accept   = in_flit.valid && in_ready_q && (state_q == COLLECT);
      full     = (wr_cnt_q == CW'(MAX_PKT_LEN));
      buf_we   = accept && !full;
      state_d  = state_q;
      wr_cnt_d = wr_cnt_q;
      rd_cnt_d = rd_cnt_q;
      ovf_d    = ovf_q;
      err_d    = 1'b0;
      unique case (state_q)
         COLLECT: begin
            if (accept) begin
               if (full) begin
                  ovf_d = 1'b1;
               end else begin
                  wr_cnt_d = wr_cnt_q + CW'(1);
               end
               if (in_flit.last) begin
                  state_d = SEND_LEN;
                  // ovf_d also covers a dropped last flit
                  err_d   = ovf_d;
               end
            end
         end
         SEND_LEN: begin
            if (out_ready) begin
               state_d  = SEND_DATA;
               rd_cnt_d = '0;
            end
         end
         SEND_DATA: begin
            if (out_ready) begin
               if (rd_cnt_q == wr_cnt_q - CW'(1)) begin
                  state_d  = COLLECT;
                  wr_cnt_d = '0;
                  rd_cnt_d = '0;
                  ovf_d    = 1'b0;
               end else begin
                  rd_cnt_d = rd_cnt_q + CW'(1);
               end
            end
         end
         default: begin
            state_d = COLLECT;
         end
      endcase
   end

   // Outputs are registered from the next state, so a stalled
   // handshake leaves state and therefore outputs unchanged.
   always_comb begin
      in_ready_d  = (state_d == COLLECT);
      out_valid_d = (state_d != COLLECT);
      busy_d      = (state_d != COLLECT);
      out_data_d  = '0;
      unique case (state_d)
         SEND_LEN:  out_data_d = {{(WIDTH-CW){1'b0}}, wr_cnt_d};
         SEND_DATA: out_data_d = rd_data;
         default:   out_data_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= COLLECT;
         wr_cnt_q    <= '0;
         rd_cnt_q    <= '0;
         ovf_q       <= 1'b0;
         err_q       <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_cnt_q    <= wr_cnt_d;
         rd_cnt_q    <= rd_cnt_d;
         ovf_q       <= ovf_d;
         err_q       <= err_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready     = in_ready_q;
   assign out_valid    = out_valid_q;
   assign out_data     = out_data_q;
   assign err_overflow = err_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_dii_glip_serializer.sv
// Self-checking bench for dii_glip_serializer: per-cycle vector table for
// reset and basic packets, hand sequences for overflow, stalls and reset.
module tb_dii_glip_serializer;
   import dii_glip_serializer_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   dii_flit     in_flit;
   logic        in_ready;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        err_overflow;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   logic [15:0] exp_q[$];

   typedef struct {
      logic        rst;
      logic        v;
      logic        l;
      logic [15:0] d;
      logic        e_ir;
      logic        e_ov;
      logic [15:0] e_od;
      logic        e_err;
      logic        e_busy;
   } vec_t;

   vec_t tbl[13];

   dii_glip_serializer #(
      .MAX_PKT_LEN (8),
      .WIDTH       (16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_flit      (in_flit),
      .in_ready     (in_ready),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .err_overflow (err_overflow),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   task automatic chk16(input string nm, input logic [15:0] act,
                        input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic r, input logic v, input logic l,
                               input logic [15:0] d, input logic ir,
                               input logic ov, input logic [15:0] od,
                               input logic er, input logic bz);
      vec_t t;
      t.rst = r; t.v = v; t.l = l; t.d = d;
      t.e_ir = ir; t.e_ov = ov; t.e_od = od; t.e_err = er; t.e_busy = bz;
      return t;
   endfunction

   function automatic logic rdy(input int mode, input int k);
      if (mode == 0) return 1'b1;
      if (k < 4) return (k % 2 == 0);
      return (k >= 24);
   endfunction

   task automatic send_pkt(input int n, input logic [15:0] base);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk1("send_in_ready", in_ready, 1'b1);
         chk1("send_no_err", err_overflow, 1'b0);
         in_flit.valid = 1'b1;
         in_flit.last  = (i == n - 1);
         in_flit.data  = base + 16'(i);
         out_ready     = 1'b1;
         @(posedge clk);
      end
   endtask

   task automatic drain(input int mode, input logic exp_err);
      int          got;
      int          k;
      logic        r;
      logic        prev_stall;
      logic [15:0] prev_data;
      got = 0;
      k = 0;
      prev_stall = 1'b0;
      prev_data = '0;
      while (got < exp_q.size() && k < 100) begin
         @(negedge clk);
         in_flit.valid = 1'b0;
         in_flit.last  = 1'b0;
         chk1("drain_err", err_overflow, (k == 0) ? exp_err : 1'b0);
         chk1("drain_valid", out_valid, 1'b1);
         chk1("drain_in_ready", in_ready, 1'b0);
         chk1("drain_busy", busy, 1'b1);
         if (prev_stall) chk16("stall_stable", out_data, prev_data);
         r = rdy(mode, k);
         out_ready = r;
         if (out_valid && r) begin
            chk16($sformatf("word%0d", got), out_data, exp_q[got]);
            got++;
         end
         prev_stall = out_valid && !r;
         prev_data = out_data;
         @(posedge clk);
         k++;
      end
      if (got < exp_q.size()) begin
         failures++;
         $display("FAIL drain_timeout: got %0d words expected %0d",
                  got, exp_q.size());
      end
      @(negedge clk);
      out_ready = 1'b1;
      chk1("done_in_ready", in_ready, 1'b1);
      chk1("done_valid", out_valid, 1'b0);
      chk1("done_busy", busy, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      in_flit = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);

      tbl[0]  = mk(1'b1, 1'b0, 1'b0, 16'h0000,
                   1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
      tbl[1]  = mk(1'b0, 1'b1, 1'b1, 16'h0077,
                   1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
      tbl[2]  = mk(1'b0, 1'b1, 1'b0, 16'h0001,
                   1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
      tbl[3]  = mk(1'b0, 1'b1, 1'b0, 16'h0002,
                   1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
      tbl[4]  = mk(1'b0, 1'b1, 1'b1, 16'h0003,
                   1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
      tbl[5]  = mk(1'b0, 1'b0, 1'b0, 16'h0000,
                   1'b0, 1'b1, 16'h0003, 1'b0, 1'b1);
      tbl[6]  = mk(1'b0, 1'b0, 1'b0, 16'h0000,
                   1'b0, 1'b1, 16'h0001, 1'b0, 1'b1);
      tbl[7]  = mk(1'b0, 1'b0, 1'b0, 16'h0000,
                   1'b0, 1'b1, 16'h0002, 1'b0, 1'b1);
      tbl[8]  = mk(1'b0, 1'b0, 1'b0, 16'h0000,
                   1'b0, 1'b1, 16'h0003, 1'b0, 1'b1);
      tbl[9]  = mk(1'b0, 1'b1, 1'b1, 16'hBEEF,
                   1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
      tbl[10] = mk(1'b0, 1'b0, 1'b0, 16'h0000,
                   1'b0, 1'b1, 16'h0001, 1'b0, 1'b1);
      tbl[11] = mk(1'b0, 1'b0, 1'b0, 16'h0000,
                   1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b1);
      tbl[12] = mk(1'b0, 1'b0, 1'b0, 16'h0000,
                   1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);

      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         chk1($sformatf("t%0d_in_ready", i), in_ready, tbl[i].e_ir);
         chk1($sformatf("t%0d_valid", i), out_valid, tbl[i].e_ov);
         if (tbl[i].e_ov || i < 2)
            chk16($sformatf("t%0d_data", i), out_data, tbl[i].e_od);
         chk1($sformatf("t%0d_err", i), err_overflow, tbl[i].e_err);
         chk1($sformatf("t%0d_busy", i), busy, tbl[i].e_busy);
         rst           = tbl[i].rst;
         in_flit.valid = tbl[i].v;
         in_flit.last  = tbl[i].l;
         in_flit.data  = tbl[i].d;
         out_ready     = 1'b1;
         @(posedge clk);
      end

      // overflow: 10 flits into an 8-deep buffer
      send_pkt(10, 16'h0000);
      exp_q = {16'd8, 16'd0, 16'd1, 16'd2, 16'd3,
               16'd4, 16'd5, 16'd6, 16'd7};
      drain(0, 1'b1);

      // backpressure, including a 20-cycle stall mid-data
      send_pkt(3, 16'h0001);
      exp_q = {16'd3, 16'd1, 16'd2, 16'd3};
      drain(1, 1'b0);

      // reset during SEND_DATA after one data word
      send_pkt(3, 16'h0011);
      @(negedge clk);
      in_flit.valid = 1'b0;
      chk1("mr_len_valid", out_valid, 1'b1);
      chk16("mr_len", out_data, 16'd3);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk16("mr_d0", out_data, 16'h0011);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk1("mr_rst_valid", out_valid, 1'b0);
      chk16("mr_rst_data", out_data, 16'h0000);
      chk1("mr_rst_busy", busy, 1'b0);
      chk1("mr_rst_err", err_overflow, 1'b0);
      chk1("mr_rst_in_ready", in_ready, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk1("mr_quiet_valid", out_valid, 1'b0);
         chk1("mr_quiet_err", err_overflow, 1'b0);
      end
      @(posedge clk);
      send_pkt(1, 16'hA5A5);
      exp_q = {16'd1, 16'hA5A5};
      drain(0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
